// File: rtl/fifo_wr_packer.sv
// Write-side packer for the n-to-1 FIFO: gathers DSIZE words into NSIZE-word beats
// (first word in the MSB slot), pads partial beats on in_last, and drives the FIFO write port.
module fifo_wr_packer #(
   parameter int                DSIZE       = 8,
   parameter int                NSIZE       = 4,
   parameter logic [DSIZE-1:0]  PAD_VALUE   = '0,
   parameter int                AF_THROTTLE = 1
) (
   input  logic                     wr_clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [DSIZE-1:0]         in_data,
   input  logic                     in_last,
   output logic                     in_ready,
   input  logic                     fifo_full,
   input  logic                     fifo_almost_full,
   output logic                     fifo_wr_en,
   output logic [DSIZE*NSIZE-1:0]   fifo_wr_data,
   output logic [15:0]              beat_cnt,
   output logic                     pad_pulse,
   output logic                     busy
);

   localparam int                     IDXW     = (NSIZE > 1) ? $clog2(NSIZE) : 1;
   localparam int                     BW       = DSIZE * NSIZE;
   localparam logic [BW-1:0]          PAD_BEAT = {NSIZE{PAD_VALUE}};
   localparam logic [IDXW-1:0]        LAST_IDX = IDXW'(NSIZE - 1);
   localparam logic                   AF_EN    = (AF_THROTTLE != 0);

   logic [BW-1:0]    pk_q, pk_new;
   logic [IDXW-1:0]  idx_q;
   logic [BW-1:0]    ob_data_q;
   logic             ob_valid_q, ob_pad_q;
   logic [15:0]      beat_cnt_q;
   logic             pad_pulse_q;

   logic stall, accept, last_slot, complete;

   // Handshake: a word transfers on in_valid && in_ready; a beat transfers to the FIFO
   // whenever fifo_wr_en is high. in_ready is uniform, so a held beat blocks all input.
   assign stall      = fifo_full | (AF_EN & fifo_almost_full);
   assign fifo_wr_en = ob_valid_q & ~stall;
   assign in_ready   = ~ob_valid_q | ~stall;
   assign accept     = in_valid & in_ready;
   assign last_slot  = (idx_q == LAST_IDX);
   assign complete   = accept & (last_slot | in_last);

   always_comb begin
      pk_new = pk_q;
      for (int i = 0; i < NSIZE; i++) begin
         if (IDXW'(i) == idx_q)
            pk_new[DSIZE*(NSIZE-1-i) +: DSIZE] = in_data;
         else if (IDXW'(i) > idx_q)
            pk_new[DSIZE*(NSIZE-1-i) +: DSIZE] = PAD_VALUE;
      end
   end

   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         pk_q        <= PAD_BEAT;
         idx_q       <= '0;
         ob_data_q   <= PAD_BEAT;
         ob_valid_q  <= 1'b0;
         ob_pad_q    <= 1'b0;
         beat_cnt_q  <= '0;
         pad_pulse_q <= 1'b0;
      end else begin
         // A completing accept during a drain cycle reloads the slot back-to-back.
         if (complete) begin
            ob_data_q  <= pk_new;
            ob_valid_q <= 1'b1;
            ob_pad_q   <= ~last_slot;
            idx_q      <= '0;
            pk_q       <= PAD_BEAT;
         end else begin
            if (accept) begin
               pk_q  <= pk_new;
               idx_q <= idx_q + IDXW'(1);
            end
            if (fifo_wr_en)
               ob_valid_q <= 1'b0;
         end
         if (fifo_wr_en)
            beat_cnt_q <= beat_cnt_q + 16'd1;
         pad_pulse_q <= fifo_wr_en & ob_pad_q;
      end
   end

   assign fifo_wr_data = ob_data_q;
   assign beat_cnt     = beat_cnt_q;
   assign pad_pulse    = pad_pulse_q;
   assign busy         = (idx_q != '0) | ob_valid_q;

endmodule
